// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared encodings and widths for the 4-channel mux scan controller.
package mux4_scan_ctrl_pkg;

    localparam int CH_W  = 2;
    localparam int D_W   = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux4_scan_ctrl_rr_pick4.sv
// Round-robin channel pick: first set mask bit above last, wrapping; last
// itself wins only when it is the only bit set.
module rr_pick4
    import mux4_scan_ctrl_pkg::*;
(
    input  logic [3:0]      mask,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] next,
    output logic            any
);

    logic [CH_W-1:0] cand;

    always_comb begin
        next = last;
        cand = last;
        any  = |mask;
        // Walk the offsets from farthest to nearest so the nearest hit wins.
        for (int k = 3; k >= 1; k--) begin
            cand = last + CH_W'(k);
            if (mask[cand]) begin
                next = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans the enabled channels of an external 4:1 mux, lets each settle for
// DWELL cycles, then offers the captured sample on a valid/ready port.
module mux4_scan_ctrl
    import mux4_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3:0]      mask,
    input  logic [D_W-1:0]  f_in,
    output logic [CH_W-1:0] sel,
    output logic [D_W-1:0]  data_out,
    output logic [CH_W-1:0] chan_out,
    output logic            valid,
    input  logic            ready,
    output logic [1:0]      dbg_state
);

    // Handshake: a sample transfers on a rising edge where valid and ready
    // are both high; valid never drops without a transfer (except on reset),
    // and ready while valid is low has no effect.

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  last;
    logic             prop;
    logic [CH_W-1:0]  next;
    logic             any;

    rr_pick4 u_pick (
        .mask (mask),
        .last (last),
        .next (next),
        .any  (any)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            data_out <= '0;
            chan_out <= '0;
            valid    <= 1'b0;
            cnt      <= '0;
            last     <= 2'd3;
            prop     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && any) begin
                        state <= SETTLE;
                        sel   <= next;
                        last  <= next;
                        cnt   <= LOAD;
                        prop  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state <= IDLE;
                        prop  <= 1'b0;
                    end else if (prop) begin
                        // First cycle after a sel change: let the mux output propagate.
                        prop <= 1'b0;
                    end else if (cnt == '0) begin
                        data_out <= f_in;
                        chan_out <= sel;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        if (en && any) begin
                            state <= SETTLE;
                            sel   <= next;
                            last  <= next;
                            cnt   <= LOAD;
                            prop  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed and randomized bench for mux4_scan_ctrl with a sample-level
// round-robin reference model.
module tb_mux4_scan_ctrl;
    import mux4_scan_ctrl_pkg::*;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ready;
    logic [3:0] mask;
    logic [2:0] f_in;
    logic [1:0] sel;
    logic [2:0] data_out;
    logic [1:0] chan_out;
    logic       valid;
    logic [1:0] dbg_state;

    logic [2:0] cd [4];
    int errors = 0;
    int checks = 0;
    int exp_last;

    always #5 clk = ~clk;

    assign f_in = cd[sel];

    mux4_scan_ctrl #(.DWELL(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mask      (mask),
        .f_in      (f_in),
        .sel       (sel),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .valid     (valid),
        .ready     (ready),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference pick: nearest enabled channel after last, last itself checked last.
    function automatic int rr(input logic [3:0] m, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (m[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    // Call with the SETTLE entry due on the next rising edge.
    task automatic get_sample(input int hold, input bit mid_en, input logic [3:0] mid_mask);
        int ch;
        int n;
        ch = rr(mask, exp_last);
        @(negedge clk);
        chk("sel_entry", sel, ch);
        chk("valid_entry", valid, 0);
        exp_last = ch;
        n = 0;
        while (!valid && n < 40) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (mid_en && n == 2) mask = mid_mask;
            if (!valid) chk("sel_settle", sel, ch);
        end
        ready = 1'b0;
        chk("valid_latency", n, DW + 1);
        chk("chan_out", chan_out, ch);
        chk("data_out", data_out, cd[ch]);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_stable", {valid, sel, chan_out, data_out}, {1'b1, 2'(ch), 2'(ch), cd[ch]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b0; mask = 4'b0000;
        cd[0] = 3'd0; cd[1] = 3'd0; cd[2] = 3'd0; cd[3] = 3'd0;
        #12;
        chk("rst_valid", valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_data", data_out, 0);
        chk("rst_chan", chan_out, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        exp_last = 3;

        // IDLE holds unless en and a nonzero mask
        mask = 4'b1111;
        repeat (3) begin @(negedge clk); chk("idle_no_en", dbg_state, IDLE); end
        en = 1'b1; mask = 4'b0000;
        repeat (3) begin @(negedge clk); chk("idle_no_mask", dbg_state, IDLE); end

        // Scenario 1: all channels, data 5,2,7,1
        cd[0] = 3'd5; cd[1] = 3'd2; cd[2] = 3'd7; cd[3] = 3'd1;
        mask = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) ready = 1'b1;
            get_sample(0, 1'b0, 4'b0000);
        end

        // Scenario 2: odd channels only
        mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            ready = 1'b1;
            get_sample(0, 1'b0, 4'b0000);
        end

        // Scenario 3: consumer stalls for 10 cycles
        mask = 4'b1111;
        ready = 1'b1;
        get_sample(10, 1'b0, 4'b0000);
        ready = 1'b1;
        get_sample(0, 1'b0, 4'b0000);

        // Scenario 4a: en dropped two cycles into SETTLE
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        exp_last = rr(mask, exp_last);
        chk("abort_sel", sel, exp_last);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_state", dbg_state, IDLE);
        repeat (6) begin @(negedge clk); chk("abort_no_valid", valid, 0); end

        // Scenario 4b: en dropped while holding a sample
        en = 1'b1;
        get_sample(0, 1'b0, 4'b0000);
        en = 1'b0;
        repeat (3) begin @(negedge clk); chk("hold_no_en_valid", valid, 1); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("hold_no_en_state", dbg_state, IDLE);
        chk("hold_no_en_cleared", valid, 0);
        repeat (3) begin @(negedge clk); chk("stay_idle", dbg_state, IDLE); end

        // Scenario 5: single channel 2, then mask moved to channel 0 mid-SETTLE
        mask = 4'b0100;
        en = 1'b1;
        get_sample(0, 1'b0, 4'b0000);
        ready = 1'b1;
        get_sample(0, 1'b1, 4'b0001);
        ready = 1'b1;
        get_sample(0, 1'b0, 4'b0000);

        // Randomized masks, data, stalls and mid-SETTLE mask changes
        for (int i = 0; i < 20; i++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) cd[c] = 3'($urandom_range(0, 7));
            ready = 1'b1;
            get_sample($urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)));
        end

        // Scenario 6: asynchronous reset in HOLD
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_sel", sel, 0);
        chk("arst_data", data_out, 0);
        chk("arst_chan", chan_out, 0);
        chk("arst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        exp_last = 3;
        mask = 4'b1111;
        en = 1'b1;
        get_sample(0, 1'b0, 4'b0000);
        chk("arst_first_pick", chan_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
